// File: rtl/parity_chk_pkg.sv
// Shared types and helpers for the multi-lane parity stream checker.
package parity_chk_pkg;

    typedef enum logic [1:0] {
        S_OK    = 2'd0,
        S_WARN  = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    // Lane data is zero-extended to 64 bits; the extra zeros leave the XOR unchanged.
    function automatic logic lane_parity_err(input logic [63:0] data,
                                             input logic        par,
                                             input logic        odd);
        return ((^data) ^ par) != odd;
    endfunction

    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/parity_lane.sv
// One lane: parity error compute (with optional inversion) and saturating error counter.
module parity_lane
    import parity_chk_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_par,
    input  logic              i_odd,
    input  logic              i_inj,
    input  logic              i_acc,
    input  logic              i_clr,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic             w_err;
    logic [CNT_W-1:0] r_cnt;

    assign w_err = lane_parity_err(64'(i_data), i_par, i_odd) ^ i_inj;
    assign o_err = w_err;
    assign o_cnt = r_cnt;

    // clr takes priority over a same-cycle error beat
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_acc && w_err && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_stream_checker.sv
// Multi-lane streaming parity checker: one valid/ready register stage, per-lane error
// tags and counters, consecutive-error alarm FSM. PARITY_CHK_INJECT_EN adds inj_mask.
module parity_stream_checker
    import parity_chk_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int DATA_W       = 8,
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        odd_mode,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [NUM_LANES-1:0]        in_par,
`ifdef PARITY_CHK_INJECT_EN
    input  logic [NUM_LANES-1:0]        inj_mask,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [NUM_LANES-1:0]        out_err,
    output logic [NUM_LANES*CNT_W-1:0]  err_cnt,
    output logic                        sticky_err,
    output logic                        alarm
);

    localparam int CONS_W = $clog2(ALARM_THRESH + 1);

    logic                        w_acc;
    logic                        w_beat_err;
    logic [NUM_LANES-1:0]        w_err;
    logic [NUM_LANES-1:0]        w_inj;
    logic [NUM_LANES-1:0][CNT_W-1:0] w_cnt;
    logic [CONS_W-1:0]           w_consec_inc;
    logic [CONS_W-1:0]           w_consec_nxt;
    state_t                      w_state_nxt;

    logic                        r_out_valid;
    logic [NUM_LANES*DATA_W-1:0] r_out_data;
    logic [NUM_LANES-1:0]        r_out_err;
    logic                        r_sticky;
    logic [CONS_W-1:0]           r_consec;
    state_t                      r_state;

`ifdef PARITY_CHK_INJECT_EN
    assign w_inj = inj_mask;
`else
    assign w_inj = '0;
`endif

    assign in_ready   = !r_out_valid || out_ready;
    assign w_acc      = in_valid && in_ready;
    assign w_beat_err = |w_err;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        parity_lane #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_data (in_data[i*DATA_W +: DATA_W]),
            .i_par  (in_par[i]),
            .i_odd  (odd_mode),
            .i_inj  (w_inj[i]),
            .i_acc  (w_acc),
            .i_clr  (clr),
            .o_err  (w_err[i]),
            .o_cnt  (w_cnt[i])
        );
        assign err_cnt[i*CNT_W +: CNT_W] = w_cnt[i];
    end

    // Output register stage; clr deliberately leaves the data path alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
        end else begin
            if (in_ready) begin
                r_out_valid <= in_valid;
            end
            if (w_acc) begin
                r_out_data <= in_data;
                r_out_err  <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sticky <= 1'b0;
        end else if (w_acc && w_beat_err) begin
            r_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_OK;
            r_consec <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_consec <= w_consec_nxt;
        end
    end

    assign w_consec_inc = r_consec + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_consec_nxt = r_consec;
        if (clr) begin
            w_state_nxt  = S_OK;
            w_consec_nxt = '0;
        end else if (w_acc) begin
            case (r_state)
                S_OK: begin
                    if (w_beat_err) begin
                        w_state_nxt  = S_WARN;
                        w_consec_nxt = CONS_W'(1);
                    end
                end
                S_WARN: begin
                    if (!w_beat_err) begin
                        w_state_nxt  = S_OK;
                        w_consec_nxt = '0;
                    end else begin
                        w_consec_nxt = w_consec_inc;
                        if (w_consec_inc == CONS_W'(ALARM_THRESH)) begin
                            w_state_nxt = S_ALARM;
                        end
                    end
                end
                S_ALARM: begin
                    w_state_nxt = S_ALARM;
                end
                default: begin
                    w_state_nxt  = S_OK;
                    w_consec_nxt = '0;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;
    assign sticky_err = r_sticky;
    assign alarm      = (r_state == S_ALARM);

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed + random bench for parity_stream_checker against a run-length reference model.
module tb_parity_stream_checker;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int CW = 2;
    localparam int TH = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst, odd_mode, clr, in_valid, in_ready, out_valid, out_ready;
    logic              sticky_err, alarm;
    logic [NL*DW-1:0]  in_data, out_data;
    logic [NL-1:0]     in_par, out_err;
    logic [NL*CW-1:0]  err_cnt;
`ifdef PARITY_CHK_INJECT_EN
    logic [NL-1:0]     inj_mask;
`endif

    always #5 clk = ~clk;

    parity_stream_checker #(
        .NUM_LANES    (NL),
        .DATA_W       (DW),
        .CNT_W        (CW),
        .ALARM_THRESH (TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .odd_mode   (odd_mode),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_par     (in_par),
`ifdef PARITY_CHK_INJECT_EN
        .inj_mask   (inj_mask),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_cnt    (err_cnt),
        .sticky_err (sticky_err),
        .alarm      (alarm)
    );

    // Reference model: the alarm is a latch set once the run of consecutive error beats reaches TH
    bit              mv, msticky, malarm;
    logic [NL*DW-1:0] md;
    logic [NL-1:0]   me;
    int              mcnt [NL];
    int              run;
    int              passed = 0;
    int              total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [NL-1:0] exp_err();
        logic [NL-1:0] e;
        for (int i = 0; i < NL; i++) begin
            int ones;
            ones = $countones(in_data[i*DW +: DW]) + int'(in_par[i]);
            e[i] = ((ones % 2) == 1) != odd_mode;
`ifdef PARITY_CHK_INJECT_EN
            e[i] = e[i] ^ inj_mask[i];
`endif
        end
        return e;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) mcnt[i] = 0;
        msticky = 0;
        malarm  = 0;
        run     = 0;
    endfunction

    // One clock: inputs already driven; check in_ready, advance model, check outputs after the edge
    task automatic step();
        logic rdy;
        logic [NL-1:0] e;
        bit acc;
        #1;
        rdy = !mv || out_ready;
        check("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        e = exp_err();
        if (rst) begin
            mv = 0; md = '0; me = '0;
            model_clear();
        end else begin
            if (rdy) mv = in_valid;
            if (acc) begin md = in_data; me = e; end
            if (clr) begin
                model_clear();
            end else if (acc) begin
                for (int i = 0; i < NL; i++)
                    if (e[i] && mcnt[i] < CMAX) mcnt[i]++;
                if (|e) begin msticky = 1; run++; end
                else run = 0;
                if (run >= TH) malarm = 1;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, mv);
        check("out_data", out_data, md);
        check("out_err", out_err, me);
        for (int i = 0; i < NL; i++)
            check($sformatf("err_cnt%0d", i), err_cnt[i*CW +: CW], mcnt[i]);
        check("sticky_err", sticky_err, msticky);
        check("alarm", alarm, malarm);
    endtask

    // Drive a beat whose lanes in bad[] carry wrong parity for the current mode
    task automatic beat(input logic [NL*DW-1:0] d, input logic [NL-1:0] bad);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < NL; i++)
            in_par[i] = (^d[i*DW +: DW]) ^ odd_mode ^ bad[i];
    endtask

    task automatic idle();
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; odd_mode = 1'b0; clr = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; in_data = '0; in_par = '0;
`ifdef PARITY_CHK_INJECT_EN
        inj_mask = '0;
`endif
        mv = 0; md = '0; me = '0;
        model_clear();
        step(); step();
        rst = 1'b0;

        // even mode, 8'h03 with par 0 is clean
        in_valid = 1'b1; in_data = {8'h00, 8'h00, 8'h00, 8'h03}; in_par = '0;
        step();
        check("t1_out_err", out_err, 4'b0000);

        // even mode, lane2 8'h01 with par 0 is an error
        in_data = {8'h00, 8'h01, 8'h00, 8'h00}; in_par = '0;
        step();
        check("t2_out_err", out_err, 4'b0100);
        check("t2_cnt2", err_cnt[2*CW +: CW], 2'd1);
        check("t2_sticky", sticky_err, 1'b1);
        idle(); clr = 1'b1; step(); clr = 1'b0;

        // odd mode, three consecutive lane1 errors -> alarm
        odd_mode = 1'b1;
        beat(32'h1122_3344, 4'b0010); step();
        check("t3_no_alarm1", alarm, 1'b0);
        beat(32'h5566_7788, 4'b0010); step();
        check("t3_no_alarm2", alarm, 1'b0);
        beat(32'h99AA_BBCC, 4'b0010); step();
        check("t3_alarm", alarm, 1'b1);
        beat(32'hDEAD_BEEF, 4'b0000); step();
        check("t3_alarm_held", alarm, 1'b1);
        idle(); clr = 1'b1; step(); clr = 1'b0;
        check("t3_clr_alarm", alarm, 1'b0);
        check("t3_clr_cnt", err_cnt, '0);

        // backpressure: one beat accepted, output held for 5 stalled cycles
        idle(); step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            beat(32'h0F0F_0000 + 32'(k), 4'b0001);
            step();
            check("t4_in_ready", in_ready, 1'b0);
            check("t4_hold", out_data, 32'h0F0F_0000);
        end
        check("t4_cnt0", err_cnt[0 +: CW], 2'd1);
        idle(); out_ready = 1'b1; step(); step();

        // saturation of lane3, then clr beside an error beat
        odd_mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            beat($urandom, 4'b1000); step();
        end
        check("t5_sat", err_cnt[3*CW +: CW], 2'd3);
        beat($urandom, 4'b1000); clr = 1'b1; step(); clr = 1'b0;
        check("t5_clr_cnt", err_cnt[3*CW +: CW], 2'd0);
        check("t5_clr_outerr", out_err, 4'b1000);
        check("t5_clr_sticky", sticky_err, 1'b0);

`ifdef PARITY_CHK_INJECT_EN
        idle(); clr = 1'b1; step(); clr = 1'b0;
        beat(32'h1234_5678, 4'b0000); inj_mask = 4'b1000; step(); inj_mask = '0;
        check("t6_inj_err", out_err, 4'b1000);
        check("t6_inj_cnt", err_cnt[3*CW +: CW], 2'd1);
`endif

        // reset with a beat in flight
        out_ready = 1'b0; beat(32'hCAFE_F00D, 4'b0000); step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_drop", out_valid, 1'b0);
        out_ready = 1'b1;

        for (int k = 0; k < 400; k++) begin
            logic [NL-1:0] bad;
            if (k == 200) begin idle(); step(); step(); odd_mode = ~odd_mode; end
            for (int i = 0; i < NL; i++) bad[i] = ($urandom_range(0, 5) == 0);
            beat($urandom, bad);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 99) == 0);
`ifdef PARITY_CHK_INJECT_EN
            inj_mask  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
`endif
            step();
        end
        rst = 1'b0; clr = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
